// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: shared widths and the operand beat payload for booth_mac16.
package booth_mac_pkg;

  localparam int unsigned ACC_W_DEF = 40;  // default accumulator/result width
  localparam int unsigned OP_W      = 16;  // operand width (fixed)
  localparam int unsigned PROD_W    = 32;  // full product width

  // One accepted operand beat as it travels through S1.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            first;
    logic            last;
    logic            is_signed;
  } beat_t;

endpackage : booth_mac_pkg

// File: rtl/booth_mac16_booth.sv
// booth_mac16_booth: combinational 16x16 Radix-4 Booth multiplier (the
// Radix4BoothWallace16 stage). Partial-product reduction is left as a flat sum
// so synthesis builds the compressor tree.
//   a_i      : multiplicand
//   b_i      : multiplier
//   signed_i : 1 = two's-complement operands, 0 = unsigned operands
//   prod_o   : 32-bit product (exact in both modes)
module booth_mac16_booth
  import booth_mac_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic              signed_i,
  output logic [PROD_W-1:0] prod_o
);

  // Two guard bits let unsigned operands be recoded as non-negative signed ones.
  localparam int unsigned EXT_W = OP_W + 2;
  localparam int unsigned NDIG  = EXT_W / 2;

  logic signed [EXT_W-1:0]  a_ext;
  logic        [EXT_W:0]    b_rec;
  logic signed [PROD_W-1:0] a_wide;
  logic signed [PROD_W-1:0] pp;
  logic signed [PROD_W-1:0] sum;

  // Booth digit selection and accumulation; all arithmetic is mod 2^32, which
  // is exact because the true product always fits the 32-bit result.
  always_comb begin
    a_ext  = signed_i ? EXT_W'($signed(a_i)) : EXT_W'(a_i);
    b_rec  = {(signed_i ? {2{b_i[OP_W-1]}} : 2'b00), b_i, 1'b0};
    a_wide = PROD_W'(a_ext);
    pp     = '0;
    sum    = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      case (b_rec[2*i +: 3])
        3'b001, 3'b010: pp = a_wide;
        3'b011:         pp = a_wide <<< 1;
        3'b100:         pp = -(a_wide <<< 1);
        3'b101, 3'b110: pp = -a_wide;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2 * i));
    end
    prod_o = sum;
  end

endmodule : booth_mac16_booth

// File: rtl/booth_mac16.sv
// booth_mac16: 3-stage pipelined multiply-accumulate over frames of beats.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand stream handshake (in_ready is combinational)
//   in_first/in_last     : frame delimiters; in_signed sampled on first beat
//   multiplicand/multiplier : 16-bit operands
//   out_valid/out_ready  : result stream handshake
//   acc_out, overflow    : frame result and sticky overflow, valid with out_valid
module booth_mac16
  import booth_mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_signed,
  input  logic [OP_W-1:0]  multiplicand,
  input  logic [OP_W-1:0]  multiplier,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  logic              stall;
  logic              accept;
  logic              frame_signed_q, frame_signed_d;
  beat_t             s1_q, s1_d;
  logic              s1_valid_q;
  logic [PROD_W-1:0] prod;
  logic              s2_valid_q;
  logic [PROD_W-1:0] s2_prod_q;
  logic              s2_first_q, s2_last_q, s2_signed_q;
  logic [ACC_W-1:0]  acc_q;
  logic              sticky_q, sticky_d;
  logic [ACC_W-1:0]  ext, addend, sum;
  logic              carry, beat_ovf;
  logic              out_valid_q;
  logic [ACC_W-1:0]  acc_out_q;
  logic              overflow_q;

  // Handshake and S1 capture; the frame's signedness follows the first beat.
  always_comb begin
    stall          = out_valid_q && !out_ready;
    in_ready       = !stall;
    accept         = in_valid && in_ready;
    frame_signed_d = in_first ? in_signed : frame_signed_q;
    s1_d           = '{a: multiplicand, b: multiplier, first: in_first,
                       last: in_last, is_signed: frame_signed_d};
  end

  booth_mac16_booth u_radix4_booth_wallace16 (
    .a_i      (s1_q.a),
    .b_i      (s1_q.b),
    .signed_i (s1_q.is_signed),
    .prod_o   (prod)
  );

  // S3 accumulate with per-mode overflow detection.
  always_comb begin
    ext          = s2_signed_q ? ACC_W'($signed(s2_prod_q)) : ACC_W'(s2_prod_q);
    addend       = s2_first_q ? '0 : acc_q;
    {carry, sum} = {1'b0, addend} + {1'b0, ext};
    beat_ovf     = s2_signed_q
                 ? ((addend[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != addend[ACC_W-1]))
                 : carry;
    sticky_d     = (s2_first_q ? 1'b0 : sticky_q) | beat_ovf;
  end

  // Pipeline registers; everything freezes while a result is refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_signed_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_q           <= '0;
      s2_valid_q     <= 1'b0;
      s2_prod_q      <= '0;
      s2_first_q     <= 1'b0;
      s2_last_q      <= 1'b0;
      s2_signed_q    <= 1'b0;
      acc_q          <= '0;
      sticky_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      acc_out_q      <= '0;
      overflow_q     <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_q           <= s1_d;
        frame_signed_q <= frame_signed_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q   <= prod;
        s2_first_q  <= s1_q.first;
        s2_last_q   <= s1_q.last;
        s2_signed_q <= s1_q.is_signed;
      end
      if (s2_valid_q) begin
        acc_q    <= sum;
        sticky_q <= sticky_d;
      end
      // A completing frame overrides the clear caused by consumption.
      if (s2_valid_q && s2_last_q) begin
        out_valid_q <= 1'b1;
        acc_out_q   <= sum;
        overflow_q  <= sticky_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign overflow  = overflow_q;

endmodule : booth_mac16

// File: tb/tb_booth_mac16.sv
// tb_booth_mac16: directed and randomized checks of booth_mac16 against an
// arithmetic frame model.
module tb_booth_mac16;

  localparam int unsigned ACC_W = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_first, in_last, in_signed;
  logic [15:0]      multiplicand, multiplier;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  booth_mac16 #(.ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_signed    (in_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .acc_out      (acc_out),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int dummy;
  bit rnd_phase = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- frame model: pure arithmetic on accepted beats ----------------
  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } res_t;

  res_t             exp_q[$];
  logic [ACC_W-1:0] m_acc    = '0;
  logic             m_sticky = 1'b0;
  logic             m_sgn    = 1'b0;

  function automatic void model_beat(input logic [15:0] a, input logic [15:0] b,
                                     input logic f, input logic l, input logic s);
    longint two40 = longint'(1) <<< 40;
    longint p, base, t;
    logic   ovf;
    if (f) begin
      m_sgn    = s;
      m_acc    = '0;
      m_sticky = 1'b0;
    end
    if (m_sgn) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      base = m_acc[ACC_W-1] ? longint'(m_acc) - two40 : longint'(m_acc);
      t    = base + p;
      ovf  = (t >= two40 / 2) || (t < -(two40 / 2));
    end else begin
      p   = longint'(a) * longint'(b);
      t   = longint'(m_acc) + p;
      ovf = (t >= two40);
    end
    m_acc    = ACC_W'(t);
    m_sticky = m_sticky | ovf;
    if (l) exp_q.push_back('{m_acc, m_sticky});
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_acc    = '0;
      m_sticky = 1'b0;
      m_sgn    = 1'b0;
    end else if (in_valid && in_ready) begin
      model_beat(multiplicand, multiplier, in_first, in_last, in_signed);
    end
  end

  // ---------------- compare process ----------------
  initial begin
    res_t             e;
    bit               stalled_prev = 1'b0;
    logic [ACC_W-1:0] held_acc = '0;
    logic             held_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (stalled_prev) begin
          check("hold_acc", 64'(acc_out), 64'(held_acc));
          check("hold_ovf", 64'(overflow), 64'(held_ovf));
        end
        if (out_valid && out_ready) begin
          check("result_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("model_acc", 64'(acc_out), 64'(e.acc));
            check("model_ovf", 64'(overflow), 64'(e.ovf));
          end
        end
        stalled_prev = out_valid && !out_ready;
        held_acc     = acc_out;
        held_ovf     = overflow;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic f,
                      input logic l, input logic s, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc      = -1;
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    in_first     = f;
    in_last      = l;
    in_signed    = s;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(done), 64'(1));
  endtask

  task automatic wait_result(input string name, input logic [ACC_W-1:0] ea,
                             input logic eo, output int seen_cyc);
    bit got = 1'b0;
    seen_cyc = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got      = 1'b1;
        seen_cyc = cyc;
      end
    end
    check({name, "_seen"}, 64'(got), 64'(1));
    if (got) begin
      check({name, "_acc"}, 64'(acc_out), 64'(ea));
      check({name, "_ovf"}, 64'(overflow), 64'(eo));
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_phase) out_ready = ($urandom_range(0, 9) < 7);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int t_acc, t_seen;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_signed = 1'b0;
    multiplicand = '0; multiplier = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_acc_out", 64'(acc_out), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Unsigned single beat and its latency.
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, t_acc);
    wait_result("u_single", 40'h00_FFFE_0001, 1'b0, t_seen);
    check("u_single_latency", 64'(t_seen - t_acc), 64'(3));

    // Signed 4-beat frame; in_signed only driven on the first beat.
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, dummy);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, dummy);
    send(16'h0003, 16'hFFFB, 1'b0, 1'b0, 1'b0, dummy);
    send(16'h7FFF, 16'h0002, 1'b0, 1'b1, 1'b0, dummy);
    wait_result("s_frame4", 40'h00_4000_FFF0, 1'b0, t_seen);

    // Unsigned overflow across 257 beats, then a clean frame.
    for (int i = 0; i < 257; i++)
      send(16'hFFFF, 16'hFFFF, 1'(i == 0), 1'(i == 256), 1'b0, dummy);
    wait_result("ovf_257", 40'h00_FDFE_0101, 1'b1, t_seen);
    send(16'd2, 16'd3, 1'b1, 1'b1, 1'b0, dummy);
    wait_result("after_ovf", 40'd6, 1'b0, t_seen);

    // Backpressure: result held, input refused, nothing lost.
    out_ready = 1'b0;
    send(16'd9, 16'd9, 1'b1, 1'b1, 1'b0, dummy);
    send(16'd5, 16'd5, 1'b1, 1'b0, 1'b0, dummy);
    send(16'd1, 16'd1, 1'b0, 1'b1, 1'b0, dummy);
    fork
      send(16'd7, 16'd1, 1'b1, 1'b1, 1'b0, dummy);
    join_none
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_acc_stable", 64'(acc_out), 64'(81));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_result("bp_first", 40'd81, 1'b0, t_seen);
    wait_result("bp_queued", 40'd26, 1'b0, t_seen);
    wait_result("bp_late", 40'd7, 1'b0, t_seen);
    wait fork;

    // Reset mid-frame discards the partial frame.
    send(16'd1, 16'd2, 1'b1, 1'b0, 1'b0, dummy);
    send(16'd3, 16'd4, 1'b0, 1'b0, 1'b0, dummy);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_acc_out", 64'(acc_out), 64'(0));
    @(posedge clk);
    #1;
    send(16'd3, 16'd4, 1'b1, 1'b1, 1'b0, dummy);
    wait_result("after_rst", 40'd12, 1'b0, t_seen);

    // Back-to-back frames with different signedness.
    send(16'd7, 16'd7, 1'b1, 1'b1, 1'b0, t_acc);
    send(16'hFFFE, 16'd3, 1'b1, 1'b1, 1'b1, t_seen);
    check("b2b_no_bubble", 64'(t_seen - t_acc), 64'(1));
    wait_result("frame_a", 40'd49, 1'b0, t_seen);
    wait_result("frame_b", 40'hFF_FFFF_FFFA, 1'b0, t_seen);

    // Randomized beats, gaps and backpressure against the model.
    rnd_phase = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int gap = $urandom_range(0, 3);
      if (gap == 3) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), dummy);
    end
    rnd_phase = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_booth_mac16
